// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   XLEN_DEFAULT : default operand/result width
//   op_e         : operation codes in RISC-V funct3 order
//   state_e      : controller states
//   helpers      : operand signedness and op-class decode
package muldiv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } state_e;

  function automatic logic op_is_div(input op_e op);
    return op[2];
  endfunction

  function automatic logic op_is_rem(input op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic op_a_signed(input op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_b_signed(input op_e op);
    return (op == OP_MUL) || (op == OP_MULH) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negation, width-generic.
//   en_i  : 1 = output is -in_i, 0 = output is in_i
//   in_i  : WIDTH-bit value
//   out_o : WIDTH-bit result
module muldiv_negate #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             en_i,
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] out_o
);

  always_comb begin
    out_o = en_i ? (~in_i + WIDTH'(1)) : in_i;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit.
// One bit per cycle: shift-add multiply / restoring divide on operand
// magnitudes, followed by a sign-fix cycle. Zero divisor and signed
// overflow complete straight from IDLE.
//   clk, reset            : clock, async active-high reset
//   in_valid / in_ready   : request handshake (op, srcA, srcB)
//   out_valid / out_ready : result handshake (result, div_by_zero)
//   flush                 : synchronous abort of any in-flight operation
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            div_by_zero
);

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic                neg_q, neg_d;
  logic [XLEN-1:0]     b_q, b_d;
  // Multiply: {product_hi, multiplier/product_lo}. Divide: {remainder, quotient}.
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                dbz_q, dbz_d;

  op_e                 op_in;
  logic                a_neg, b_neg;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic                div_zero, div_ovf;

  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_next;
  logic [XLEN:0]       div_shift, div_diff;
  logic [2*XLEN-1:0]   div_next;

  logic [2*XLEN-1:0]   fix_in, fix_out;
  logic [XLEN-1:0]     fix_res;

  assign op_in    = op_e'(op);
  assign in_ready = (state_q == ST_IDLE) && !flush;

  assign out_valid   = (state_q == ST_DONE);
  assign result      = result_q;
  assign div_by_zero = dbz_q;

  // Operand magnitudes and special-case detection at accept time.
  always_comb begin
    a_neg    = op_a_signed(op_in) && srcA[XLEN-1];
    b_neg    = op_b_signed(op_in) && srcB[XLEN-1];
    a_mag    = a_neg ? (~srcA + XLEN'(1)) : srcA;
    b_mag    = b_neg ? (~srcB + XLEN'(1)) : srcB;
    div_zero = op_is_div(op_in) && (srcB == '0);
    div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
               (srcA == {1'b1, {(XLEN-1){1'b0}}}) && (srcB == '1);
  end

  // One iteration of each datapath.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    // Remainder is always below the divisor, so the shifted value needs
    // one extra bit and the borrow out of that bit decides the quotient bit.
    div_shift = acc_q[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, b_q};
    div_next  = div_diff[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                               : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  end

  // Sign fix: quotient and remainder are zero-extended so one 2*XLEN negator
  // serves every op; the low XLEN bits of the negated value are exact.
  always_comb begin
    if (!op_is_div(op_q))     fix_in = acc_q;
    else if (op_is_rem(op_q)) fix_in = {{XLEN{1'b0}}, acc_q[2*XLEN-1:XLEN]};
    else                      fix_in = {{XLEN{1'b0}}, acc_q[XLEN-1:0]};
  end

  muldiv_negate #(
    .WIDTH (2*XLEN)
  ) u_negate (
    .en_i  (neg_q),
    .in_i  (fix_in),
    .out_o (fix_out)
  );

  always_comb begin
    if (op_is_div(op_q) || (op_q == OP_MUL)) fix_res = fix_out[XLEN-1:0];
    else                                     fix_res = fix_out[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    dbz_d    = dbz_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          op_d  = op_in;
          neg_d = op_is_rem(op_in) ? a_neg : (a_neg ^ b_neg);
          b_d   = b_mag;
          acc_d = {{XLEN{1'b0}}, a_mag};
          dbz_d = 1'b0;
          if (div_zero) begin
            state_d  = ST_DONE;
            dbz_d    = 1'b1;
            result_d = op_is_rem(op_in) ? srcA : '1;
          end else if (div_ovf) begin
            state_d  = ST_DONE;
            result_d = op_is_rem(op_in) ? '0 : srcA;
          end else begin
            state_d = ST_CALC;
            cnt_d   = CNT_W'(XLEN);
          end
        end
      end
      ST_CALC: begin
        acc_d = op_is_div(op_q) ? div_next : mul_next;
        if (cnt_q != '0)          cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1))   state_d = ST_FIX;
      end
      ST_FIX: begin
        result_d = fix_res;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MUL;
      neg_q    <= 1'b0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] srcA;
  logic [XLEN-1:0] srcB;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            div_by_zero;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(
    .XLEN (XLEN)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
    .srcA        (srcA),
    .srcB        (srcB),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: RISC-V M semantics from plain wide arithmetic.
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b, output logic dbz);
    longint     sa, sb;
    logic [63:0] ua, ub, p;
    logic [31:0] r;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    dbz = (o >= 3'd4) && (b == 32'd0);
    r   = '0;
    case (o)
      3'd0: begin p = sa * sb;           r = p[31:0];  end
      3'd1: begin p = sa * sb;           r = p[63:32]; end
      3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
      3'd3: begin p = ua * ub;           r = p[63:32]; end
      3'd4: begin if (b == 0) r = '1; else begin p = sa / sb; r = p[31:0]; end end
      3'd5: begin if (b == 0) r = '1; else r = a / b; end
      3'd6: begin if (b == 0) r = a;  else begin p = sa % sb; r = p[31:0]; end end
      default: begin if (b == 0) r = a; else r = a % b; end
    endcase
    return r;
  endfunction

  function automatic int model_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if ((o >= 3'd4) && (b == 32'd0)) return 1;
    if (((o == 3'd4) || (o == 3'd6)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
    return XLEN + 2;
  endfunction

  // Full transaction with out_ready held high; latency counts edges from the
  // accepting edge to the first cycle out_valid is seen.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input string tag);
    logic [31:0] er;
    logic        ed;
    int          lat;
    er = model(o, a, b, ed);
    @(negedge clk);
    chk({tag, "_ready"}, {63'b0, in_ready}, 64'd1);
    in_valid = 1'b1; op = o; srcA = a; srcB = b;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 3'($urandom); srcA = $urandom; srcB = $urandom;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(model_lat(o, a, b)));
    chk({tag, "_res"}, {32'b0, result}, {32'b0, er});
    chk({tag, "_dbz"}, {63'b0, div_by_zero}, {63'b0, ed});
    @(posedge clk); #1;
    chk({tag, "_ret"}, {62'b0, out_valid, in_ready}, 64'b01);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    bit          seen;
    int          n;

    reset = 1'b1; in_valid = 1'b0; op = '0; srcA = '0; srcB = '0;
    flush = 1'b0; out_ready = 1'b1;
    #1;
    chk("reset_out", {29'b0, out_valid, div_by_zero, result}, 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_ready", {63'b0, in_ready}, 64'd1);

    // Directed multiply / divide vectors.
    do_op(3'd0, 32'd7,         32'hFFFF_FFFD, "mul");
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, "mulh");
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu");
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2,         "div");
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2,         "rem");
    do_op(3'd5, 32'd100,       32'd7,         "divu");
    do_op(3'd7, 32'd100,       32'd7,         "remu");
    do_op(3'd5, 32'd5,         32'd0,         "divu0");
    do_op(3'd6, 32'd5,         32'd0,         "rem0");
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "divovf");
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "removf");

    // Randomised ops, biased toward the zero-divisor and overflow corners.
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      do_op(ro, ra, rb, $sformatf("rand%0d", i));
    end

    // Back-pressure in DONE.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; op = 3'd0; srcA = 32'd3; srcB = 32'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
    chk("stall_seen", {63'b0, out_valid}, 64'd1);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk($sformatf("stall_hold%0d", k), {30'b0, out_valid, in_ready, result}, {30'b0, 2'b10, 32'd15});
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_release", {62'b0, out_valid, in_ready}, 64'b01);

    // Flush at CALC cycle 5 discards the op.
    @(negedge clk);
    in_valid = 1'b1; op = 3'd5; srcA = 32'd1000; srcB = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("flush_no_valid", {63'b0, seen}, 64'd0);

    // Flush in IDLE masks a request.
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; op = 3'd0; srcA = 32'd9; srcB = 32'd9;
    #1;
    chk("flush_idle_ready", {63'b0, in_ready}, 64'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush_idle_back", {62'b0, out_valid, in_ready}, 64'b01);
    do_op(3'd0, 32'd3, 32'd4, "after_flush");

    // Reset mid-CALC.
    @(negedge clk);
    in_valid = 1'b1; op = 3'd1; srcA = $urandom; srcB = $urandom;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_mid_out", {29'b0, out_valid, div_by_zero, result}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_mid_ready", {63'b0, in_ready}, 64'd1);
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("rst_mid_no_valid", {63'b0, seen}, 64'd0);
    do_op(3'd7, 32'hDEAD_BEEF, 32'd1000, "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
